yarp_writeback: RTL and testbench



---
 rtl/yarp_pkg.sv | 45 ++++
 rtl/yarp_wb_ldq.sv | 72 +++++++
 rtl/yarp_writeback.sv | 122 ++++++++++++
 tb/tb_yarp_writeback.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared types for the YARP writeback stage: load funct3 codes, the load-queue
// entry layout and the load-result formatter.
package yarp_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } ld_funct3_e;

    // funct3 is kept raw so that reserved codes survive and fall back to a full word.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [1:0]            addr_lo;
    } ld_entry_t;

    localparam int LD_ENTRY_W = $bits(ld_entry_t);

    function automatic logic [XLEN-1:0] format_load(
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo,
        input logic [XLEN-1:0] w
    );
        logic [XLEN-1:0] byte_sh;
        logic [XLEN-1:0] half_sh;
        logic [XLEN-1:0] res;
        byte_sh = w >> {addr_lo, 3'b000};
        half_sh = w >> {addr_lo[1], 4'b0000};
        case (funct3)
            F3_LB:   res = {{24{byte_sh[7]}}, byte_sh[7:0]};
            F3_LH:   res = {{16{half_sh[15]}}, half_sh[15:0]};
            F3_LBU:  res = {24'b0, byte_sh[7:0]};
            F3_LHU:  res = {16'b0, half_sh[15:0]};
            default: res = w;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/yarp_wb_ldq.sv
// In-order queue of outstanding loads; per-slot valid bits double as the
// full/empty flags and feed the register busy bitmap.
module yarp_wb_ldq
    import yarp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [LD_ENTRY_W-1:0]         push_entry,
    input  logic                          pop,
    output logic [LD_ENTRY_W-1:0]         head,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH*LD_ENTRY_W-1:0]   entries,
    output logic [DEPTH-1:0]              valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LD_ENTRY_W-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Push and pop can only hit the same slot when full or empty, which the
    // guards below exclude, so the two valid-bit updates never collide.
    assign full    = valid[wr_ptr];
    assign empty   = !valid[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= '0;
        end else begin
            if (do_push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= next_ptr(rd_ptr);
            end
        end
    end

    // NOTE: entry storage is deliberately not reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i*LD_ENTRY_W +: LD_ENTRY_W] = mem[i];
        end
    end

endmodule

// File: rtl/yarp_writeback.sv
// Regfile write-side initiator: arbitrates execute results against load responses.
// Optional macro YARP_WB_BYPASS_EN adds a combinational forwarding port.
module yarp_writeback
    import yarp_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [4:0]            ex_rd_i,
    input  logic [31:0]           ex_data_i,
    input  logic                  ld_issue_i,
    input  logic [4:0]            ld_rd_i,
    input  logic [2:0]            ld_funct3_i,
    input  logic [1:0]            ld_addr_lo_i,
    output logic                  ld_ready_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [31:0]           mem_rsp_data_i,
    output logic [4:0]            rd_addr_o,
    output logic                  wr_en_o,
    output logic [31:0]           wr_data_o,
    output logic [31:0]           busy_o,
    output logic                  err_o
`ifdef YARP_WB_BYPASS_EN
    ,
    output logic                  byp_valid_o,
    output logic [4:0]            byp_rd_o,
    output logic [31:0]           byp_data_o
`endif
);

    ld_entry_t                       push_entry;
    ld_entry_t                       head;
    ld_entry_t                       scan_entry;
    logic                            q_full;
    logic                            q_empty;
    logic [LD_DEPTH*LD_ENTRY_W-1:0]  q_entries;
    logic [LD_DEPTH-1:0]             q_valid;
    logic                            pop;
    logic                            nxt_valid;
    logic [4:0]                      nxt_rd;
    logic [31:0]                     nxt_data;

    assign push_entry = '{rd: ld_rd_i, funct3: ld_funct3_i, addr_lo: ld_addr_lo_i};

    yarp_wb_ldq #(
        .DEPTH (LD_DEPTH)
    ) u_ldq (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (ld_issue_i),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty),
        .entries    (q_entries),
        .valid      (q_valid)
    );

    // Memory responses cannot be back-pressured, so they always win the port.
    assign pop        = mem_rsp_valid_i && !q_empty;
    assign ex_ready_o = !pop;
    assign ld_ready_o = !q_full;

    // NOTE: combinational blocks use blocking assignments with a default first,
    // so no latch is inferred on any path.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_rd    = '0;
        nxt_data  = '0;
        if (pop) begin
            nxt_valid = (head.rd != '0);
            nxt_rd    = head.rd;
            nxt_data  = format_load(head.funct3, head.addr_lo, mem_rsp_data_i);
        end else if (ex_valid_i) begin
            nxt_valid = (ex_rd_i != '0);
            nxt_rd    = ex_rd_i;
            nxt_data  = ex_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_o   <= 1'b0;
            rd_addr_o <= '0;
            wr_data_o <= '0;
            err_o     <= 1'b0;
        end else begin
            wr_en_o <= nxt_valid;
            if (nxt_valid) begin
                rd_addr_o <= nxt_rd;
                wr_data_o <= nxt_data;
            end
            if (mem_rsp_valid_i && q_empty) begin
                err_o <= 1'b1;
            end
        end
    end

    // Derived from live entries so duplicate destinations clear naturally.
    always_comb begin
        busy_o     = '0;
        scan_entry = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            scan_entry = q_entries[i*LD_ENTRY_W +: LD_ENTRY_W];
            if (q_valid[i]) begin
                busy_o[scan_entry.rd] = 1'b1;
            end
        end
        busy_o[0] = 1'b0;
    end

`ifdef YARP_WB_BYPASS_EN
    assign byp_valid_o = nxt_valid;
    assign byp_rd_o    = nxt_rd;
    assign byp_data_o  = nxt_data;
`endif

endmodule

// File: tb/tb_yarp_writeback.sv
// Self-checking bench for yarp_writeback: load-format table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_yarp_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_rd_i;
    logic [31:0] ex_data_i;
    logic        ld_issue_i;
    logic [4:0]  ld_rd_i;
    logic [2:0]  ld_funct3_i;
    logic [1:0]  ld_addr_lo_i;
    logic        ld_ready_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic [4:0]  rd_addr_o;
    logic        wr_en_o;
    logic [31:0] wr_data_o;
    logic [31:0] busy_o;
    logic        err_o;

    always #5 clk = ~clk;

    yarp_writeback #(.LD_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ex_valid_i      (ex_valid_i),
        .ex_ready_o      (ex_ready_o),
        .ex_rd_i         (ex_rd_i),
        .ex_data_i       (ex_data_i),
        .ld_issue_i      (ld_issue_i),
        .ld_rd_i         (ld_rd_i),
        .ld_funct3_i     (ld_funct3_i),
        .ld_addr_lo_i    (ld_addr_lo_i),
        .ld_ready_o      (ld_ready_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .rd_addr_o       (rd_addr_o),
        .wr_en_o         (wr_en_o),
        .wr_data_o       (wr_data_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] a;
    } mentry_t;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  a;
        logic [4:0]  rd;
        logic [31:0] word;
        logic [31:0] exp;
    } ld_vec_t;

    mentry_t     mq[$];
    bit          m_err;
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference formatting by plain arithmetic on the word.
    function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
        longint unsigned wv, bv, hv;
        wv = w;
        bv = (wv / (64'd1 << (8 * a))) % 256;
        hv = (wv / (64'd1 << (16 * (a / 2)))) % 65536;
        case (f3)
            3'd0:    return (bv >= 128) ? 32'(bv + 64'hFFFFFF00) : 32'(bv);
            3'd1:    return (hv >= 32768) ? 32'(hv + 64'hFFFF0000) : 32'(hv);
            3'd4:    return 32'(bv);
            3'd5:    return 32'(hv);
            default: return w;
        endcase
    endfunction

    // One clock: drive, check combinational outputs at negedge, update the
    // model, then check the registered port just after the next posedge.
    task automatic drive(input bit exv, input logic [4:0] exrd, input logic [31:0] exd,
                         input bit ldi, input logic [4:0] ldrd, input logic [2:0] f3,
                         input logic [1:0] a, input bit rspv, input logic [31:0] rspd);
        logic [31:0] busy_exp;
        bit          pop;
        bit          push;
        ex_valid_i      = exv;
        ex_rd_i         = exrd;
        ex_data_i       = exd;
        ld_issue_i      = ldi;
        ld_rd_i         = ldrd;
        ld_funct3_i     = f3;
        ld_addr_lo_i    = a;
        mem_rsp_valid_i = rspv;
        mem_rsp_data_i  = rspd;
        @(negedge clk);
        pop  = rspv && (mq.size() > 0);
        push = ldi && (mq.size() < DEPTH);
        busy_exp = '0;
        foreach (mq[i]) busy_exp[mq[i].rd] = 1'b1;
        busy_exp[0] = 1'b0;
        check("ex_ready", {31'b0, ex_ready_o}, {31'b0, !pop});
        check("ld_ready", {31'b0, ld_ready_o}, {31'b0, mq.size() < DEPTH});
        check("busy", busy_o, busy_exp);
        m_wen = 1'b0;
        if (pop) begin
            m_wen  = (mq[0].rd != 0);
            m_rd   = mq[0].rd;
            m_data = ref_fmt(mq[0].f3, mq[0].a, rspd);
            void'(mq.pop_front());
        end else if (exv) begin
            m_wen  = (exrd != 0);
            m_rd   = exrd;
            m_data = exd;
        end
        if (rspv && !pop) m_err = 1'b1;
        if (push) mq.push_back('{rd: ldrd, f3: f3, a: a});
        @(posedge clk);
        #1;
        check("wr_en", {31'b0, wr_en_o}, {31'b0, m_wen});
        if (m_wen) begin
            check("rd_addr", {27'b0, rd_addr_o}, {27'b0, m_rd});
            check("wr_data", wr_data_o, m_data);
        end
        check("err", {31'b0, err_o}, {31'b0, m_err});
    endtask

    task automatic idle();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 0, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mq.delete();
        m_err = 1'b0;
        m_wen = 1'b0;
        #1;
        check("rst_busy", busy_o, 32'd0);
        check("rst_wr_en", {31'b0, wr_en_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_rd_addr", {27'b0, rd_addr_o}, 32'd0);
        check("rst_wr_data", wr_data_o, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        ld_vec_t vecs[13];
        bit          exv;
        logic [4:0]  exrd;
        logic [31:0] exd;
        bit          held;
        bit          ldi;
        bit          rspv;

        vecs[0]  = '{3'b000, 2'd2, 5'd3,  32'h0080FF00, 32'hFFFFFF80};
        vecs[1]  = '{3'b100, 2'd2, 5'd3,  32'h0080FF00, 32'h00000080};
        vecs[2]  = '{3'b001, 2'd2, 5'd3,  32'h0080FF00, 32'h00000080};
        vecs[3]  = '{3'b001, 2'd0, 5'd4,  32'h0080FF00, 32'hFFFFFF00};
        vecs[4]  = '{3'b101, 2'd0, 5'd4,  32'h0080FF00, 32'h0000FF00};
        vecs[5]  = '{3'b010, 2'd1, 5'd5,  32'h12345678, 32'h12345678};
        vecs[6]  = '{3'b000, 2'd3, 5'd6,  32'h80000000, 32'hFFFFFF80};
        vecs[7]  = '{3'b100, 2'd1, 5'd8,  32'h0000AB00, 32'h000000AB};
        vecs[8]  = '{3'b000, 2'd0, 5'd9,  32'h0000007F, 32'h0000007F};
        vecs[9]  = '{3'b011, 2'd2, 5'd10, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[10] = '{3'b110, 2'd0, 5'd11, 32'h80000080, 32'h80000080};
        vecs[11] = '{3'b101, 2'd3, 5'd12, 32'hBEEF1234, 32'h0000BEEF};
        vecs[12] = '{3'b001, 2'd1, 5'd13, 32'h00018001, 32'hFFFF8001};

        ex_valid_i = 0; ex_rd_i = 0; ex_data_i = 0;
        ld_issue_i = 0; ld_rd_i = 0; ld_funct3_i = 0; ld_addr_lo_i = 0;
        mem_rsp_valid_i = 0; mem_rsp_data_i = 0;
        reset_n = 1'b1;
        m_err = 0; m_wen = 0; m_rd = 0; m_data = 0;
        #2;
        do_reset();

        // Execute only
        drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 3'd0, 2'd0, 0, 32'd0);
        check("exec_wr_en", {31'b0, wr_en_o}, 32'd1);
        check("exec_rd", {27'b0, rd_addr_o}, 32'd5);
        check("exec_data", wr_data_o, 32'hDEADBEEF);
        idle();
        check("exec_pulse_end", {31'b0, wr_en_o}, 32'd0);

        // Load formatting table
        foreach (vecs[i]) begin
            drive(0, 5'd0, 32'd0, 1, vecs[i].rd, vecs[i].f3, vecs[i].a, 0, 32'd0);
            drive(0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 1, vecs[i].word);
            check("tbl_wr_en", {31'b0, wr_en_o}, 32'd1);
            check("tbl_rd", {27'b0, rd_addr_o}, {27'b0, vecs[i].rd});
            check("tbl_data", wr_data_o, vecs[i].exp);
        end

        // Collision: load response beats execute, execute follows a cycle later
        drive(0, 5'd0, 32'd0, 1, 5'd3, 3'b000, 2'd0, 0, 32'd0);
        drive(1, 5'd9, 32'h11111111, 0, 5'd0, 3'd0, 2'd0, 1, 32'h000000F0);
        check("coll_ld_rd", {27'b0, rd_addr_o}, 32'd3);
        check("coll_ld_data", wr_data_o, 32'hFFFFFFF0);
        drive(1, 5'd9, 32'h11111111, 0, 5'd0, 3'd0, 2'd0, 0, 32'd0);
        check("coll_ex_rd", {27'b0, rd_addr_o}, 32'd9);
        check("coll_ex_data", wr_data_o, 32'h11111111);

        // Queue full with duplicate destination
        drive(0, 5'd0, 32'd0, 1, 5'd7, 3'b010, 2'd0, 0, 32'd0);
        drive(0, 5'd0, 32'd0, 1, 5'd7, 3'b010, 2'd0, 0, 32'd0);
        check("full_ld_ready", {31'b0, ld_ready_o}, 32'd0);
        check("full_busy7", {31'b0, busy_o[7]}, 32'd1);
        drive(0, 5'd0, 32'd0, 1, 5'd7, 3'b010, 2'd0, 0, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 1, 32'hAAAA0001);
        check("full_wr1", {27'b0, rd_addr_o}, 32'd7);
        check("full_busy7_mid", {31'b0, busy_o[7]}, 32'd1);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 1, 32'hAAAA0002);
        check("full_wr2", wr_data_o, 32'hAAAA0002);
        check("full_busy7_clr", {31'b0, busy_o[7]}, 32'd0);
        check("full_ld_ready_back", {31'b0, ld_ready_o}, 32'd1);

        // x0 handling
        drive(1, 5'd0, 32'h55555555, 0, 5'd0, 3'd0, 2'd0, 0, 32'd0);
        check("x0_exec_no_wr", {31'b0, wr_en_o}, 32'd0);
        drive(0, 5'd0, 32'd0, 1, 5'd0, 3'b010, 2'd0, 0, 32'd0);
        check("x0_busy", busy_o, 32'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h12121212);
        check("x0_load_no_wr", {31'b0, wr_en_o}, 32'd0);

        // Response with empty queue is sticky until reset
        drive(0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h0);
        check("err_set", {31'b0, err_o}, 32'd1);
        idle();
        idle();
        check("err_sticky", {31'b0, err_o}, 32'd1);
        do_reset();

        // Reset mid-flight flushes the queue; late response then flags an error
        drive(1, 5'd6, 32'h0BADF00D, 1, 5'd12, 3'b010, 2'd0, 0, 32'd0);
        check("mid_busy12", {31'b0, busy_o[12]}, 32'd1);
        check("mid_wr_en", {31'b0, wr_en_o}, 32'd1);
        do_reset();
        drive(0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 1, 32'h77777777);
        check("late_rsp_err", {31'b0, err_o}, 32'd1);
        do_reset();

        // Randomized traffic; a stalled execute source keeps its inputs
        held = 0; exv = 0; exrd = 0; exd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                exv  = ($urandom_range(0, 1) == 1);
                exrd = 5'($urandom);
                exd  = $urandom;
            end
            ldi  = ($urandom_range(0, 2) != 0);
            rspv = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            held = exv && rspv;
            drive(exv, exrd, exd, ldi, 5'($urandom), 3'($urandom), 2'($urandom),
                  rspv, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
